tempo_scheduler: RTL and testbench

Game-tempo controller that sequences the note-tick rate for a play session. Holds an internal down-counter equivalent to a rate divider and computes its reload period from the current difficulty level. Speeds up every fixed number of ticks and supports pause/resume. Ends the song after a fixed tick count. Downstream note-scroll and scoring logic consume `tick`. `period_out` can configure an external rate divider's load value.

---
 rtl/tempo_scheduler.sv | 148 ++++++++++++++
 tb/tb_tempo_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tempo_scheduler.sv
// tempo_scheduler: note-tick tempo controller. A reloadable down-counter sets the
// tick rate, which speeds up with difficulty level; supports pause and fixed song length.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | one cycle; clear level/song progress, load period(0)
// RUN    | counter decrements; tick and reload at zero
// PAUSED | counter, level and tick counters frozen
// DONE   | song finished; waiting for start
module tempo_scheduler #(
  parameter int                RATE_W          = 28,
  parameter logic [RATE_W-1:0] BASE_PERIOD     = 28'd12_499_999,
  parameter logic [RATE_W-1:0] STEP            = 28'd1_000_000,
  parameter logic [RATE_W-1:0] MIN_PERIOD      = 28'd2_499_999,
  parameter int                TICKS_PER_LEVEL = 16,
  parameter int                MAX_LEVEL       = 7,
  parameter int                SONG_TICKS      = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic              tick,
  output logic [RATE_W-1:0] period_out,
  output logic [2:0]        level,
  output logic              busy,
  output logic              paused,
  output logic              done
);

  localparam int PW     = RATE_W + 3;
  localparam int LVL_W  = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam int SONG_W = (SONG_TICKS > 1) ? $clog2(SONG_TICKS) : 1;

  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(TICKS_PER_LEVEL - 1);
  localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(SONG_TICKS - 1);
  localparam logic [2:0]        LEVEL_MAX = 3'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state;
  logic [RATE_W-1:0]   counter;
  logic [LVL_W-1:0]    lvl_cnt;
  logic [SONG_W-1:0]   song_cnt;

  logic                lvl_wrap;
  logic                song_last;
  logic [2:0]          level_up;
  logic [2:0]          level_nxt;
  logic [RATE_W-1:0]   reload;

  // Product is widened so a large level*STEP clamps to the floor instead of wrapping.
  function automatic logic [RATE_W-1:0] period_of(input logic [2:0] lvl);
    logic [PW-1:0] prod;
    logic [PW:0]   need;
    logic [PW:0]   base_x;
    prod   = PW'(lvl) * PW'(STEP);
    need   = {1'b0, prod} + (PW+1)'(MIN_PERIOD);
    base_x = (PW+1)'(BASE_PERIOD);
    if (base_x < need)
      period_of = MIN_PERIOD;
    else
      period_of = RATE_W'(base_x - {1'b0, prod});
  endfunction

  assign tick      = (state == S_RUN) && (counter == '0);
  assign lvl_wrap  = (lvl_cnt == LVL_LAST);
  assign song_last = (song_cnt == SONG_LAST);
  assign level_up  = (level >= LEVEL_MAX) ? level : level + 3'd1;
  assign level_nxt = lvl_wrap ? level_up : level;
  assign reload    = period_of(level_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      counter    <= BASE_PERIOD;
      level      <= '0;
      lvl_cnt    <= '0;
      song_cnt   <= '0;
      period_out <= BASE_PERIOD;
      busy       <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
    end else begin
      period_out <= period_of(level);
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          level    <= '0;
          lvl_cnt  <= '0;
          song_cnt <= '0;
          counter  <= period_of(3'd0);
          state    <= S_RUN;
        end
        S_RUN: begin
          if (tick) begin
            counter  <= reload;
            level    <= level_nxt;
            lvl_cnt  <= lvl_wrap ? '0 : lvl_cnt + 1'b1;
            song_cnt <= song_cnt + 1'b1;
          end else begin
            counter <= counter - 1'b1;
          end
          // The final tick ends the song even if pause arrives with it.
          if (tick && song_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (pause) begin
            state  <= S_PAUSED;
            paused <= 1'b1;
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state  <= S_RUN;
            paused <= 1'b0;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          paused <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tempo_scheduler.sv
// Directed bench for tempo_scheduler with small periods; expected tick cycles,
// levels and periods are hand-computed from the tempo rules.
module tb_tempo_scheduler;

  localparam int RATE_W = 28;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              pause;
  logic              tick;
  logic [RATE_W-1:0] period_out;
  logic [2:0]        level;
  logic              busy;
  logic              paused;
  logic              done;

  int n_chk  = 0;
  int n_pass = 0;
  int rel    = 0;

  // Free run: tick cycles relative to the start cycle, and level/period seen after ticks 1..11.
  int ticks_a [12] = '{11, 21, 29, 37, 43, 49, 53, 57, 61, 65, 69, 73};
  int lvl_a   [11] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
  int per_a   [11] = '{9, 7, 7, 5, 5, 3, 3, 3, 3, 3, 3};
  // Second run: restart, ignored start, 5-cycle pause, pause on a tick.
  int ticks_b [5]  = '{11, 21, 34, 42, 51};

  tempo_scheduler #(
    .RATE_W          (RATE_W),
    .BASE_PERIOD     (28'd9),
    .STEP            (28'd2),
    .MIN_PERIOD      (28'd3),
    .TICKS_PER_LEVEL (2),
    .MAX_LEVEL       (7),
    .SONG_TICKS      (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .period_out (period_out),
    .level      (level),
    .busy       (busy),
    .paused     (paused),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tick"},   32'(tick),       32'd0);
    check({tag, "_level"},  32'(level),      32'd0);
    check({tag, "_period"}, 32'(period_out), 32'd9);
    check({tag, "_busy"},   32'(busy),       32'd0);
    check({tag, "_paused"}, 32'(paused),     32'd0);
    check({tag, "_done"},   32'(done),       32'd0);
  endtask

  task automatic next_cyc();
    @(negedge clk);
    rel++;
  endtask

  function automatic logic in_a(input int r);
    foreach (ticks_a[i]) if (ticks_a[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic in_b(input int r);
    foreach (ticks_b[i]) if (ticks_b[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Run A: free run to the end of the song.
    start = 1'b1;
    rel   = 0;
    next_cyc();
    start = 1'b0;
    check("a_load_busy", 32'(busy), 32'd1);
    check("a_load_tick", 32'(tick), 32'd0);
    for (int k = 0; k < 75; k++) begin
      next_cyc();
      check($sformatf("a_tick@%0d", rel), 32'(tick), 32'(in_a(rel)));
      check($sformatf("a_busy@%0d", rel), 32'(busy), 32'(rel <= 73));
      check($sformatf("a_done@%0d", rel), 32'(done), 32'(rel >= 74));
      for (int i = 0; i < 11; i++) begin
        if (rel == ticks_a[i] + 2) begin
          check($sformatf("a_level_t%0d", i + 1),  32'(level),      32'(lvl_a[i]));
          check($sformatf("a_period_t%0d", i + 1), 32'(period_out), 32'(per_a[i]));
        end
      end
    end

    // Run B: restart from DONE, then stimulus scheduled by relative cycle.
    start = 1'b1;
    rel   = 0;
    next_cyc();
    start = 1'b0;
    check("b_load_busy", 32'(busy), 32'd1);
    check("b_load_done", 32'(done), 32'd0);
    for (int k = 0; k < 52; k++) begin
      next_cyc();
      check($sformatf("b_tick@%0d", rel), 32'(tick), 32'(in_b(rel)));
      check($sformatf("b_paused@%0d", rel), 32'(paused),
            32'((rel >= 24 && rel <= 28) || (rel >= 43 && rel <= 45)));
      check($sformatf("b_busy@%0d", rel), 32'(busy), 32'd1);
      if (rel == 2) check("b_level_restart", 32'(level), 32'd0);
      if (rel == 3) check("b_period_restart", 32'(period_out), 32'd9);
      case (rel)
        5:  start = 1'b1;
        6:  start = 1'b0;
        23: pause = 1'b1;
        28: pause = 1'b0;
        42: pause = 1'b1;
        45: pause = 1'b0;
        53: begin start = 1'b1; reset = 1'b1; end
        default: ;
      endcase
    end

    next_cyc();
    check_idle("midrun_rst");
    reset = 1'b0;
    start = 1'b0;
    next_cyc();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_tick", 32'(tick), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
